sa_tile_sequencer: RTL and testbench

//  Top-level phase controller for the 128x128 systolic array. On a start request it runs
//  NUM_TILES tiles back to back. Each tile has three phases: weight load, input feed and

---
 rtl/sa_tile_sequencer_if.sv | 34 +++
 rtl/sa_tile_sequencer.sv | 137 +++++++++++++
 tb/tb_sa_tile_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_tile_sequencer_if.sv
// Host/array-side bundle for the systolic-array tile sequencer.
// Host drives start/num_tiles/hold/abort; the sequencer drives the rest.
interface sa_tile_sequencer_if #(
  parameter int CNT_W  = 9,
  parameter int TILE_W = 8
);
  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              hold;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              w_load_en;
  logic              in_feed_en;
  logic              out_drain_en;
  logic [CNT_W-1:0]  phase_idx;
  logic [TILE_W-1:0] tile_idx;
  logic [2:0]        phase;
  logic              done;

  modport master (
    output start, num_tiles, hold, abort,
    input  ready, busy, w_load_en, in_feed_en,
    input  out_drain_en, phase_idx, tile_idx,
    input  phase, done
  );

  modport slave (
    input  start, num_tiles, hold, abort,
    output ready, busy, w_load_en, in_feed_en,
    output out_drain_en, phase_idx, tile_idx,
    output phase, done
  );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Phase controller for the 128x128 systolic array: runs N tiles of
// weight load / input feed / output drain back to back.
module sa_tile_sequencer #(
  parameter int ARRAY_DIM = 128,
  parameter int FEED_LEN  = 128,
  parameter int DRAIN_LEN = 255,
  parameter int CNT_W     = 9,
  parameter int TILE_W    = 8
) (
  input logic                clk,
  input logic                rstn,
  sa_tile_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] W_LAST =
    CNT_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0] F_LAST =
    CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] D_LAST =
    CNT_W'(DRAIN_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic              last_tile;

  assign last_tile =
    (tile_q == (ntiles_q - TILE_W'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
    end
  end

  // abort outranks hold so a stalled run can still be cancelled
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (!bus.hold) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            ntiles_d = bus.num_tiles;
            tile_d   = '0;
            idx_d    = '0;
            state_d  = (bus.num_tiles != '0) ?
                       LOAD_W : DONE;
          end
        end
        LOAD_W: begin
          if (idx_q == W_LAST) begin
            state_d = FEED;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        FEED: begin
          if (idx_q == F_LAST) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (idx_q == D_LAST) begin
            idx_d = '0;
            if (last_tile) begin
              state_d = DONE;
            end else begin
              state_d = LOAD_W;
              tile_d  = tile_q + TILE_W'(1);
            end
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready        = 1'b0;
    bus.busy         = 1'b0;
    bus.w_load_en    = 1'b0;
    bus.in_feed_en   = 1'b0;
    bus.out_drain_en = 1'b0;
    bus.done         = 1'b0;
    bus.phase        = state_q;
    bus.phase_idx    = idx_q;
    bus.tile_idx     = tile_q;
    unique case (1'b1)
      (state_q == IDLE): bus.ready = 1'b1;
      (state_q == LOAD_W): begin
        bus.busy      = 1'b1;
        bus.w_load_en = !bus.hold;
      end
      (state_q == FEED): begin
        bus.busy       = 1'b1;
        bus.in_feed_en = !bus.hold;
      end
      (state_q == DRAIN): begin
        bus.busy         = 1'b1;
        bus.out_drain_en = !bus.hold;
      end
      (state_q == DONE): bus.done = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer: driver queues expected
// enable/done events, a negedge monitor pops and compares them.
module tb_sa_tile_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  ph;
    logic [8:0]  idx;
    logic [7:0]  tile;
    logic [5:0]  fl;
  } ev_t;

  localparam int BIG = 1 << 30;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  sa_tile_sequencer_if #(.CNT_W(9), .TILE_W(8)) bus ();

  sa_tile_sequencer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] a,
                       input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (rstn && (bus.w_load_en || bus.in_feed_en ||
                 bus.out_drain_en || bus.done)) begin
      act.cyc  = cyc;
      act.ph   = bus.phase;
      act.idx  = bus.phase_idx;
      act.tile = bus.tile_idx;
      act.fl   = {bus.ready, bus.busy, bus.w_load_en,
                  bus.in_feed_en, bus.out_drain_en,
                  bus.done};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event act=%h", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int cy);
    while (cyc < cy) tick();
  endtask

  task automatic push_run(input int base, input int n,
                          input int hold_at,
                          input int hold_len,
                          input int stop);
    int  k;
    int  len;
    ev_t e;
    k = 0;
    for (int t = 0; t < n; t++) begin
      for (int p = 1; p <= 3; p++) begin
        len = (p == 3) ? 255 : 128;
        for (int i = 0; i < len; i++) begin
          if (k < stop) begin
            e.cyc  = base + 1 + k +
                     ((k >= hold_at) ? hold_len : 0);
            e.ph   = 3'(p);
            e.idx  = 9'(i);
            e.tile = 8'(t);
            e.fl   = {1'b0, 1'b1, p == 1, p == 2,
                      p == 3, 1'b0};
            exp_q.push_back(e);
          end
          k++;
        end
      end
    end
    if (stop > k) begin
      e.cyc  = base + 1 + k +
               ((k >= hold_at) ? hold_len : 0);
      e.ph   = 3'd4;
      e.idx  = 9'd0;
      e.tile = (n == 0) ? 8'd0 : 8'(n - 1);
      e.fl   = 6'b000001;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run(input logic [7:0] n);
    bus.start     = 1'b1;
    bus.num_tiles = n;
    tick();
    bus.start     = 1'b0;
    bus.num_tiles = 8'd0;
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      tick();
      b++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    #1;
    check({nm, "_ready_after"},
          {61'd0, bus.ready, bus.phase}, {61'd0, 1'b1, 3'd0});
  endtask

  initial begin
    int c;
    checks        = 0;
    errors        = 0;
    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.num_tiles = 8'd0;
    bus.hold      = 1'b0;
    bus.abort     = 1'b0;
    #3;
    check("reset_vals",
          {bus.ready, bus.busy, bus.w_load_en,
           bus.in_feed_en, bus.out_drain_en, bus.done,
           bus.phase, bus.phase_idx, bus.tile_idx},
          {6'b100000, 3'd0, 9'd0, 8'd0});
    tick();
    tick();
    rstn = 1'b1;
    tick();

    c = cyc;
    push_run(c, 1, BIG, 0, BIG);
    start_run(8'd1);
    drain("one_tile");

    tick();
    c = cyc;
    push_run(c, 3, BIG, 0, BIG);
    start_run(8'd3);
    wait_until(c + 600);
    bus.start     = 1'b1;
    bus.num_tiles = 8'd7;
    tick();
    bus.start     = 1'b0;
    bus.num_tiles = 8'd0;
    drain("three_tile");

    tick();
    c = cyc;
    push_run(c, 1, 138, 5, BIG);
    start_run(8'd1);
    wait_until(c + 139);
    bus.hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      #1;
      check("hold_frozen",
            {bus.w_load_en, bus.in_feed_en,
             bus.out_drain_en, bus.phase, bus.phase_idx},
            {3'b000, 3'd2, 9'd10});
      tick();
    end
    bus.hold = 1'b0;
    drain("hold_run");

    tick();
    c = cyc;
    push_run(c, 1, BIG, 0, 356);
    start_run(8'd1);
    wait_until(c + 357);
    bus.hold  = 1'b1;
    bus.abort = 1'b1;
    #1;
    check("abort_cycle",
          {bus.out_drain_en, bus.phase, bus.phase_idx},
          {1'b0, 3'd3, 9'd100});
    tick();
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    #1;
    check("abort_idle",
          {bus.ready, bus.done, bus.phase, bus.phase_idx},
          {1'b1, 1'b0, 3'd0, 9'd0});
    tick();
    tick();
    tick();
    check("abort_no_done", 64'(exp_q.size()), 64'd0);
    c = cyc;
    push_run(c, 1, BIG, 0, BIG);
    start_run(8'd1);
    drain("after_abort");

    tick();
    c = cyc;
    push_run(c, 0, BIG, 0, BIG);
    start_run(8'd0);
    drain("zero_tiles");

    tick();
    c = cyc;
    push_run(c, 2, BIG, 0, 50);
    start_run(8'd2);
    wait_until(c + 51);
    rstn = 1'b0;
    #1;
    check("mid_reset",
          {bus.ready, bus.busy, bus.w_load_en,
           bus.in_feed_en, bus.out_drain_en, bus.done,
           bus.phase, bus.phase_idx, bus.tile_idx},
          {6'b100000, 3'd0, 9'd0, 8'd0});
    tick();
    tick();
    rstn = 1'b1;
    for (int w = 0; w < 5; w++) tick();
    #1;
    check("reset_wait",
          {bus.ready, bus.phase, 32'(exp_q.size())},
          {1'b1, 3'd0, 32'd0});

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
